// File: rtl/mult_booth_r4_hs_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, the decoded Booth
// operation and the digit decoder.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic two;
    } booth_op_t;

    // Triplet is {Q[1], Q[0], Q[-1]}.
    function automatic booth_op_t booth_decode(input logic [2:0] trip);
        booth_op_t op;
        op = '{zero: 1'b0, neg: 1'b0, two: 1'b0};
        unique case (trip)
            3'b000, 3'b111: op.zero = 1'b1;
            3'b001, 3'b010: op.neg = 1'b0;
            3'b011:         op.two = 1'b1;
            3'b100: begin
                op.neg = 1'b1;
                op.two = 1'b1;
            end
            3'b101, 3'b110: op.neg = 1'b1;
            default:        op.zero = 1'b1;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mult_booth_r4_hs_ppgen.sv
// Radix-4 Booth partial-product generator: selects 0, +-M or +-2M.
// Negation is returned as an inverted magnitude plus a carry-in for the adder.
module booth_r4_ppgen
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH+1:0] m,
    input  booth_op_t        op,
    output logic [WIDTH+1:0] pp,
    output logic             cin
);

    logic [WIDTH+1:0] mag;

    always_comb begin
        mag = op.two ? {m[WIDTH:0], 1'b0} : m;
        if (op.zero) begin
            mag = '0;
        end
        pp  = op.neg ? ~mag : mag;
        cin = op.neg;
    end

endmodule

// File: rtl/mult_booth_r4_hs.sv
// Radix-4 Booth multiplier with valid/ready handshakes, one Booth digit per cycle.
// Operands carry two extension bits so one datapath serves signed and unsigned.
module mult_booth_r4_hs
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               busy
);

    localparam int unsigned NDIG = WIDTH / 2 + 1;
    localparam int unsigned CW   = $clog2(NDIG);
    localparam int unsigned EW   = WIDTH + 2;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("mult_booth_r4_hs: WIDTH must be even and >= 4");
    end

    mult_state_e        state_q, state_d;
    logic [EW-1:0]      a_q, a_d;
    logic [EW-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               sgn_q, sgn_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [EW-1:0]       m_ext;
    booth_op_t           op;
    logic [EW-1:0]       pp;
    logic                cin;
    logic [EW-1:0]       a_sum;
    logic signed [2*EW-1:0] shifted;

    // Extension is applied at use; the latched mode selects sign or zero fill.
    assign m_ext = {{2{sgn_q & m_q[WIDTH-1]}}, m_q};
    assign op    = booth_decode({q_q[1], q_q[0], qm1_q});

    booth_r4_ppgen #(
        .WIDTH (WIDTH)
    ) u_ppgen (
        .m   (m_ext),
        .op  (op),
        .pp  (pp),
        .cin (cin)
    );

    // Carry-out of the EW-bit sum is intentionally dropped.
    assign a_sum   = a_q + pp + {{(EW-1){1'b0}}, cin};
    assign shifted = $signed({a_sum, q_q}) >>> 2;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    a_d     = '0;
                    q_d     = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
                    qm1_d   = 1'b0;
                    m_d     = in_a;
                    sgn_d   = in_signed;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = shifted[2*EW-1:EW];
                q_d   = shifted[EW-1:0];
                qm1_d = q_q[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DIG) begin
                    prod_d  = shifted[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CALC);
    assign out_valid = (state_q == DONE);
    assign out_prod  = prod_q;

endmodule

// File: tb/tb_mult_booth_r4_hs.sv
// Directed bench for the Booth multiplier: a WIDTH=32 instance with hand-computed
// vectors and a WIDTH=8 instance checked against a behavioural product.
module tb_mult_booth_r4_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, flush, in_valid, in_signed, out_ready;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid, busy;
    logic [63:0] out_prod;

    logic        flush_8, in_valid_8, in_signed_8, out_ready_8;
    logic [7:0]  in_a_8, in_b_8;
    logic        in_ready_8, out_valid_8, busy_8;
    logic [15:0] out_prod_8;

    int vectors = 0;
    int miscompares = 0;

    mult_booth_r4_hs #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_b     (rst_b),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    mult_booth_r4_hs #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_b     (rst_b),
        .flush     (flush_8),
        .in_valid  (in_valid_8),
        .in_ready  (in_ready_8),
        .in_signed (in_signed_8),
        .in_a      (in_a_8),
        .in_b      (in_b_8),
        .out_valid (out_valid_8),
        .out_ready (out_ready_8),
        .out_prod  (out_prod_8),
        .busy      (busy_8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the 32-bit instance with out_ready already high.
    task automatic op32(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
        int guard;
        int lat;
        int busy_cnt;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat       = 0;
        busy_cnt  = busy ? 1 : 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, " latency"}, 64'(lat), 64'd17);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd17);
        check({tag, " prod"}, out_prod, exp);
        tick();
        check({tag, " back_to_idle"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin
        int lat;
        int seen;
        logic [7:0]  a8, b8;
        logic        s8;
        logic [15:0] exp8;

        rst_b = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        flush_8 = 1'b0; in_valid_8 = 1'b0; in_signed_8 = 1'b0; out_ready_8 = 1'b0;
        in_a_8 = '0; in_b_8 = '0;
        #3;
        check("reset outputs", 64'({in_ready, busy, out_valid}), 64'b100);
        check("reset prod", out_prod, 64'd0);
        check("reset prod8", 64'(out_prod_8), 64'd0);
        #20 rst_b = 1'b1;
        tick();

        op32("u101x63", 1'b0, 32'd101, 32'd63, 64'h18DB);
        op32("s-7x5", 1'b1, 32'hFFFF_FFF9, 32'd5, 64'hFFFF_FFFF_FFFF_FFDD);
        op32("u_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        op32("s_ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        op32("s_minsq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        op32("s_minmax", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);

        // Backpressure: result held while the next operand waits with in_valid high.
        out_ready = 1'b0;
        in_signed = 1'b0; in_a = 32'd1000; in_b = 32'd1000; in_valid = 1'b1;
        tick();
        in_signed = 1'b1; in_a = 32'h1234_5678; in_b = 32'hFFFF_FFFE;
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("bp latency", 64'(lat), 64'd17);
        check("bp prod", out_prod, 64'hF4240);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp hold", 64'({out_valid, in_ready, busy}), 64'b100);
            check("bp prod stable", out_prod, 64'hF4240);
        end
        out_ready = 1'b1;
        tick();
        check("bp release", 64'({in_ready, out_valid}), 64'b10);
        check("bp prod kept", out_prod, 64'hF4240);
        tick();
        in_valid = 1'b0;
        check("bp next accepted", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("bp next prod", out_prod, 64'hFFFF_FFFF_DB97_5310);
        tick();

        // Flush on the 8th CALC cycle discards the operation.
        in_signed = 1'b0; in_a = 32'd77; in_b = 32'd77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush to idle", 64'({in_ready, busy, out_valid}), 64'b100);
        check("flush prod kept", out_prod, 64'hFFFF_FFFF_DB97_5310);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush no valid", 64'(seen), 64'd0);

        // Flush beats a simultaneous handshake.
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush vs accept", 64'({in_ready, busy}), 64'b10);
        op32("u3x4", 1'b0, 32'd3, 32'd4, 64'd12);

        // Asynchronous reset in the middle of CALC.
        in_signed = 1'b0; in_a = 32'd77; in_b = 32'd77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2 rst_b = 1'b0;
        #1;
        check("midreset outputs", 64'({in_ready, busy, out_valid}), 64'b100);
        check("midreset prod", out_prod, 64'd0);
        #3 rst_b = 1'b1;
        tick();
        op32("u5x6", 1'b0, 32'd5, 32'd6, 64'd30);

        // WIDTH=8 instance: random operands, modes and output stalls.
        for (int n = 0; n < 2000; n++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            s8 = 1'($urandom_range(0, 1));
            if (s8) exp8 = $signed(a8) * $signed(b8);
            else    exp8 = a8 * b8;
            in_a_8 = a8; in_b_8 = b8; in_signed_8 = s8; in_valid_8 = 1'b1;
            tick();
            in_valid_8 = 1'b0;
            lat = 0;
            while (!out_valid_8 && lat < 30) begin
                tick();
                lat++;
            end
            check("w8 latency", 64'(lat), 64'd5);
            repeat ($urandom_range(0, 3)) tick();
            check("w8 prod", 64'(out_prod_8), 64'(exp8));
            out_ready_8 = 1'b1;
            tick();
            out_ready_8 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
